alu_control_muldiv: RTL and testbench

- Next-generation ALU control for the MIPS core.
- Keeps the combinational op/funct decode to a 4-bit ALU control code.
- Adds a parametrised iterative multiply/divide unit with HI/LO registers for mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Sits between the main control/ID stage and the EX stage, and raises a stall to the pipeline while a multi-cycle operation occupies HI/LO.

---
 rtl/alu_control_muldiv_pkg.sv | 94 +++++++++
 rtl/alu_control_muldiv_if.sv | 34 +++
 rtl/alu_control_muldiv_muldiv_core.sv | 156 +++++++++++++++
 rtl/alu_control_muldiv.sv | 92 +++++++++
 tb/tb_alu_control_muldiv.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_control_muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module : alu_ctrl_pkg
//  Brief  : ALUOp, funct and control-code constants, FSM state encoding and
//           decode helpers shared by the ALU control / mul-div slice.
//  Rev    : 1.0
// ============================================================================
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_XOR   = 6'b100110;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_SLTU  = 6'b101011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_XOR  = 4'b0011;
    localparam logic [3:0] CTRL_ADDU = 4'b0100;
    localparam logic [3:0] CTRL_SUBU = 4'b0101;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SLTU = 4'b1000;
    localparam logic [3:0] CTRL_NOP  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Encoding matches funct[1:0] of the mul/div group.
    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_kind_t;

    function automatic logic is_muldiv(input logic [1:0] op, input logic [5:0] funct);
        return (op == ALUOP_RTYPE) && (funct[5:2] == 4'b0110);
    endfunction

    function automatic logic is_hilo(input logic [1:0] op, input logic [5:0] funct);
        return (op == ALUOP_RTYPE) && (funct[5:2] == 4'b0100);
    endfunction

    function automatic logic [3:0] decode_ctrl(input logic [1:0] op, input logic [5:0] funct);
        logic [3:0] ctrl;
        ctrl = CTRL_AND;
        if (op == ALUOP_ADD) begin
            ctrl = CTRL_ADD;
        end else if (op == ALUOP_SUB) begin
            ctrl = CTRL_SUB;
        end else if (op == ALUOP_RTYPE) begin
            case (funct)
                FUNCT_OR:   ctrl = CTRL_OR;
                FUNCT_XOR:  ctrl = CTRL_XOR;
                FUNCT_ADD:  ctrl = CTRL_ADD;
                FUNCT_SUB:  ctrl = CTRL_SUB;
                FUNCT_AND:  ctrl = CTRL_AND;
                FUNCT_SLT:  ctrl = CTRL_SLT;
                FUNCT_ADDU: ctrl = CTRL_ADDU;
                FUNCT_SUBU: ctrl = CTRL_SUBU;
                FUNCT_SLTU: ctrl = CTRL_SLTU;
                default: begin
                    if (is_muldiv(op, funct) || is_hilo(op, funct)) begin
                        ctrl = CTRL_NOP;
                    end
                end
            endcase
        end
        return ctrl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_control_muldiv_if.sv
`default_nettype none
// ============================================================================
//  Module : alu_control_muldiv_if
//  Brief  : ID/EX-side bundle of the ALU control / mul-div block.
//  Rev    : 1.0
// ============================================================================
interface alu_control_muldiv_if #(
    parameter int WIDTH = 32
) ();
    logic [1:0]       op;
    logic [5:0]       funct;
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       control;
    logic             stall;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hilo_rdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output op, funct, valid, a, b,
        input  control, stall, busy, done, div_by_zero, hilo_rdata, hi, lo
    );

    modport slave (
        input  op, funct, valid, a, b,
        output control, stall, busy, done, div_by_zero, hilo_rdata, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/alu_control_muldiv_muldiv_core.sv
`default_nettype none
// ============================================================================
//  Module : muldiv_core
//  Brief  : Iterative shift-add multiplier / restoring divider with sign fix.
//  Rev    : 1.0
// ============================================================================
module muldiv_core
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_start,
    input  md_kind_t              i_kind,
    input  wire logic [WIDTH-1:0] i_a,
    input  wire logic [WIDTH-1:0] i_b,
    output logic                  o_idle,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_dbz,
    output logic                  o_wr,
    output logic [WIDTH-1:0]      o_hi,
    output logic [WIDTH-1:0]      o_lo
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [2*WIDTH-1:0]     r_prod;
    logic [WIDTH-1:0]       r_rem;
    logic [WIDTH-1:0]       r_opb;
    logic                   r_is_div;
    logic                   r_neg_res;
    logic                   r_neg_rem;
    logic                   r_dbz_pend;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_dbz;

    logic                   w_idle;
    logic                   w_step;
    logic                   w_fix;
    logic                   w_go;
    logic                   w_signed;
    logic                   w_div;
    logic                   w_a_neg;
    logic                   w_b_neg;
    logic [WIDTH-1:0]       w_a_mag;
    logic [WIDTH-1:0]       w_b_mag;
    logic [WIDTH:0]         w_sum;
    logic [WIDTH:0]         w_shift;
    logic [WIDTH:0]         w_diff;
    logic [2*WIDTH-1:0]     w_prod_fix;
    logic [WIDTH-1:0]       w_quo_fix;
    logic [WIDTH-1:0]       w_rem_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = RUN;
            RUN:     if (r_cnt == CNT_W'(1)) w_state_nxt = FIX;
            FIX:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_idle = (r_state == IDLE);
        w_step = (r_state == RUN);
        w_fix  = (r_state == FIX);
    end

    assign w_go     = i_start && w_idle;
    assign w_signed = (i_kind == MD_MULT) || (i_kind == MD_DIV);
    assign w_div    = (i_kind == MD_DIV) || (i_kind == MD_DIVU);
    assign w_a_neg  = w_signed && i_a[WIDTH-1];
    assign w_b_neg  = w_signed && i_b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;

    // Multiply: add multiplicand into the upper half when LSB set, then shift right.
    assign w_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opb} : '0);
    // Divide: dividend bits stream out of r_prod[WIDTH-1:0] while quotient bits shift in.
    assign w_shift = {r_rem, r_prod[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_opb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_prod     <= '0;
            r_rem      <= '0;
            r_opb      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dbz_pend <= 1'b0;
        end else if (w_go) begin
            r_cnt      <= CNT_W'(WIDTH);
            r_prod     <= {{WIDTH{1'b0}}, w_a_mag};
            r_rem      <= '0;
            r_opb      <= w_b_mag;
            r_is_div   <= w_div;
            r_neg_res  <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_div && w_a_neg;
            r_dbz_pend <= w_div && (i_b == '0);
        end else if (w_step) begin
            r_cnt <= r_cnt - CNT_W'(1);
            if (r_is_div) begin
                r_rem                <= w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
                r_prod[WIDTH-1:0]    <= {r_prod[WIDTH-2:0], ~w_diff[WIDTH]};
            end else begin
                r_prod <= {w_sum, r_prod[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= w_fix;
            r_dbz  <= w_fix && r_dbz_pend;
            if (w_go) begin
                r_busy <= 1'b1;
            end else if (w_fix) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign w_prod_fix = r_neg_res ? -r_prod : r_prod;
    assign w_quo_fix  = r_neg_res ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0];
    assign w_rem_fix  = r_neg_rem ? -r_rem : r_rem;

    assign o_idle = w_idle;
    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_dbz  = r_dbz;
    assign o_wr   = w_fix;
    assign o_hi   = r_is_div ? w_rem_fix : w_prod_fix[2*WIDTH-1:WIDTH];
    assign o_lo   = r_is_div ? w_quo_fix : w_prod_fix[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/alu_control_muldiv.sv
`default_nettype none
// ============================================================================
//  Module : alu_control_muldiv
//  Brief  : ALU control decode, HI/LO registers and mul/div issue/stall logic.
//  Rev    : 1.0
// ============================================================================
module alu_control_muldiv
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    alu_control_muldiv_if.slave bus
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_is_muldiv;
    logic             w_is_hilo;
    logic             w_issue;
    logic             w_idle;
    logic             w_mthi;
    logic             w_mtlo;
    logic             w_core_wr;
    logic             w_core_busy;
    logic             w_core_done;
    logic             w_core_dbz;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;
    logic [WIDTH-1:0] w_rdata;

    assign w_is_muldiv = is_muldiv(bus.op, bus.funct);
    assign w_is_hilo   = is_hilo(bus.op, bus.funct);
    assign w_issue     = bus.valid && w_is_muldiv && w_idle;
    assign w_mthi      = bus.valid && w_idle && (bus.op == ALUOP_RTYPE) && (bus.funct == FUNCT_MTHI);
    assign w_mtlo      = bus.valid && w_idle && (bus.op == ALUOP_RTYPE) && (bus.funct == FUNCT_MTLO);

    muldiv_core #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_issue),
        .i_kind  (md_kind_t'(bus.funct[1:0])),
        .i_a     (bus.a),
        .i_b     (bus.b),
        .o_idle  (w_idle),
        .o_busy  (w_core_busy),
        .o_done  (w_core_done),
        .o_dbz   (w_core_dbz),
        .o_wr    (w_core_wr),
        .o_hi    (w_core_hi),
        .o_lo    (w_core_lo)
    );

    // Core writes and mthi/mtlo never collide: the moves only land while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_core_wr) begin
            r_hi <= w_core_hi;
            r_lo <= w_core_lo;
        end else begin
            if (w_mthi) r_hi <= bus.a;
            if (w_mtlo) r_lo <= bus.a;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (bus.op == ALUOP_RTYPE) begin
            if (bus.funct == FUNCT_MFHI)      w_rdata = r_hi;
            else if (bus.funct == FUNCT_MFLO) w_rdata = r_lo;
        end
    end

    assign bus.control     = decode_ctrl(bus.op, bus.funct);
    assign bus.stall       = bus.valid && !w_idle && (w_is_muldiv || w_is_hilo);
    assign bus.busy        = w_core_busy;
    assign bus.done        = w_core_done;
    assign bus.div_by_zero = w_core_dbz;
    assign bus.hilo_rdata  = w_rdata;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_muldiv.sv
`default_nettype none
// ============================================================================
//  Module : tb_alu_control_muldiv
//  Brief  : Directed vector bench for ALU control decode and the mul/div unit.
//  Rev    : 1.0
// ============================================================================
module tb_alu_control_muldiv;
    import alu_ctrl_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;

    alu_control_muldiv_if #(.WIDTH(W)) bus ();

    alu_control_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [5:0] funct;
        logic [3:0] exp;
    } dec_vec_t;

    typedef struct {
        logic [5:0]   funct;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } md_vec_t;

    dec_vec_t dv [16];
    md_vec_t  mv [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.valid = v;
        bus.op    = 2'b10;
        bus.funct = f;
        bus.a     = a;
        bus.b     = b;
    endtask

    // Waits for done after an issue edge; returns number of edges taken.
    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            lat = k;
            if (bus.done) break;
        end
    endtask

    initial begin
        int lat;
        logic saw_done;

        dv[0]  = '{2'b00, 6'b000000, 4'b0010};
        dv[1]  = '{2'b01, 6'b101010, 4'b0110};
        dv[2]  = '{2'b10, 6'b100101, 4'b0001};
        dv[3]  = '{2'b10, 6'b100110, 4'b0011};
        dv[4]  = '{2'b10, 6'b100000, 4'b0010};
        dv[5]  = '{2'b10, 6'b100010, 4'b0110};
        dv[6]  = '{2'b10, 6'b100100, 4'b0000};
        dv[7]  = '{2'b10, 6'b101010, 4'b0111};
        dv[8]  = '{2'b10, 6'b100001, 4'b0100};
        dv[9]  = '{2'b10, 6'b100011, 4'b0101};
        dv[10] = '{2'b10, 6'b101011, 4'b1000};
        dv[11] = '{2'b10, 6'b011000, 4'b1111};
        dv[12] = '{2'b10, 6'b011011, 4'b1111};
        dv[13] = '{2'b10, 6'b010000, 4'b1111};
        dv[14] = '{2'b10, 6'b000111, 4'b0000};
        dv[15] = '{2'b11, 6'b100000, 4'b0000};

        mv[0] = '{6'b011000, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        mv[1] = '{6'b011001, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1, 1'b0};
        mv[2] = '{6'b011011, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0};
        mv[3] = '{6'b011010, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        mv[4] = '{6'b011010, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        mv[5] = '{6'b011010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        mv[6] = '{6'b011000, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        mv[7] = '{6'b011011, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
        mv[8] = '{6'b011010, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 6'b000000, '0, '0);
        bus.op = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",  {63'd0, bus.busy},  64'd0);
        chk("reset_done",  {63'd0, bus.done},  64'd0);
        chk("reset_hi",    {32'd0, bus.hi},    64'd0);
        chk("reset_lo",    {32'd0, bus.lo},    64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            bus.valid = 1'b0;
            bus.op    = dv[i].op;
            bus.funct = dv[i].funct;
            #1;
            chk($sformatf("decode_%0d", i), {60'd0, bus.control}, {60'd0, dv[i].exp});
        end

        // Each vector issues in the done cycle of the previous one.
        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, mv[i].funct, mv[i].a, mv[i].b);
            @(posedge clk); #1;
            bus.valid = 1'b0;
            chk($sformatf("md%0d_busy", i), {63'd0, bus.busy}, 64'd1);
            wait_done(lat);
            chk($sformatf("md%0d_latency", i), 64'(lat), 64'd33);
            chk($sformatf("md%0d_hi", i),  {32'd0, bus.hi}, {32'd0, mv[i].hi});
            chk($sformatf("md%0d_lo", i),  {32'd0, bus.lo}, {32'd0, mv[i].lo});
            chk($sformatf("md%0d_dbz", i), {63'd0, bus.div_by_zero}, {63'd0, mv[i].dbz});
            chk($sformatf("md%0d_idle", i), {63'd0, bus.busy}, 64'd0);
        end
        @(posedge clk); #1;
        chk("done_pulse_width", {63'd0, bus.done}, 64'd0);

        // mfhi waits behind a multiply; an independent add does not.
        drive(1'b1, FUNCT_MULT, 32'h00010000, 32'h00030000);
        @(posedge clk); #1;
        bus.valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, FUNCT_ADD, 32'd1, 32'd2);
        #1;
        chk("add_no_stall", {63'd0, bus.stall}, 64'd0);
        chk("add_ctrl", {60'd0, bus.control}, {60'd0, CTRL_ADD});
        @(posedge clk); #1;
        drive(1'b1, FUNCT_MFHI, '0, '0);
        #1;
        chk("mfhi_stall", {63'd0, bus.stall}, 64'd1);
        lat = 3;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            lat++;
            if (bus.done) break;
            chk("mfhi_stall_run", {63'd0, bus.stall}, 64'd1);
        end
        chk("mfhi_done_lat", 64'(lat), 64'd33);
        chk("mfhi_released", {63'd0, bus.stall}, 64'd0);
        chk("mfhi_rdata", {32'd0, bus.hilo_rdata}, 64'h3);
        chk("mfhi_lo", {32'd0, bus.lo}, 64'h0);
        bus.valid = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a divide.
        drive(1'b1, FUNCT_DIVU, 32'd1000, 32'd3);
        @(posedge clk); #1;
        bus.valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_reset_busy", {63'd0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_busy", {63'd0, bus.busy}, 64'd0);
        chk("async_hi",   {32'd0, bus.hi},   64'd0);
        chk("async_lo",   {32'd0, bus.lo},   64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        drive(1'b1, FUNCT_MTLO, 32'h00001234, '0);
        @(posedge clk); #1;
        chk("mtlo_lo", {32'd0, bus.lo}, 64'h1234);
        drive(1'b1, FUNCT_MTHI, 32'h0000ABCD, '0);
        @(posedge clk); #1;
        chk("mthi_hi", {32'd0, bus.hi}, 64'hABCD);
        drive(1'b1, FUNCT_MFLO, '0, '0);
        #1;
        chk("mflo_rdata", {32'd0, bus.hilo_rdata}, 64'h1234);
        bus.valid = 1'b0;
        saw_done = 1'b0;
        repeat (36) begin
            @(posedge clk); #1;
            if (bus.done) saw_done = 1'b1;
        end
        chk("aborted_no_done", {63'd0, saw_done}, 64'd0);
        chk("aborted_lo_kept", {32'd0, bus.lo}, 64'h1234);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
